instr_fetch_ir: RTL and testbench

Instruction fetch and instruction-register stage of the CPU. It sits between instruction memory and the program-counter/branch unit. Each instruction cycle it:
- reads the instruction word at the current `pc` over a req/ack memory handshake;
- latches the word into the IR and presents it to the control sequencer;
- once execution is signalled done, issues the one-cycle `REPC`/`INC` strobe that makes the PC unit advance or branch using the held `ir_opcode`.

---
 rtl/instr_fetch_ir_if.sv | 21 ++
 rtl/instr_fetch_ir.sv | 160 ++++++++++++++++
 tb/tb_instr_fetch_ir.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_ir_if.sv
// Instruction-memory read port shared by the fetch stage (master) and the memory (slave).
interface instr_fetch_ir_if;
    logic        imem_req;
    logic [9:0]  imem_addr;
    logic        imem_ack;
    logic [11:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/instr_fetch_ir.sv
// Instruction fetch + IR stage: fetches the word at pc, holds it for the sequencer, then strobes REPC/INC.
// Optional ack-wait timeout with sticky fetch_err is compiled in with IF_FETCH_TIMEOUT_EN.
module instr_fetch_ir #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    reset_ir,
    input  logic                    run,
    input  logic [9:0]              pc,
    instr_fetch_ir_if.master        imem,
    output logic [3:0]              ir_opcode,
    output logic [7:0]              ir_operand_addr,
    output logic                    ir_valid,
    input  logic                    ex_done,
    output logic                    REPC,
    output logic                    INC,
    output logic                    fetch_err
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_timeout_range
        $error("instr_fetch_ir: TIMEOUT_CYCLES must be in 1..255");
    end

`ifdef IF_FETCH_TIMEOUT_EN
    typedef enum logic [2:0] {IDLE, REQ, LOAD, ADVANCE, ERR} state_t;
    localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       fetch_err_q, fetch_err_d;
`else
    typedef enum logic [2:0] {IDLE, REQ, LOAD, ADVANCE} state_t;
`endif

    state_t     state_q, state_d;
    logic       imem_req_q, imem_req_d;
    logic [9:0] imem_addr_q, imem_addr_d;
    logic [3:0] ir_opcode_q, ir_opcode_d;
    logic [7:0] ir_operand_q, ir_operand_d;
    logic       ir_valid_q, ir_valid_d;
    logic       repc_q, repc_d;
    logic       inc_q, inc_d;

    always_comb begin
        state_d      = state_q;
        imem_req_d   = imem_req_q;
        imem_addr_d  = imem_addr_q;
        ir_opcode_d  = ir_opcode_q;
        ir_operand_d = ir_operand_q;
        ir_valid_d   = ir_valid_q;
        repc_d       = 1'b0;
        inc_d        = 1'b0;
`ifdef IF_FETCH_TIMEOUT_EN
        wait_cnt_d   = wait_cnt_q;
        fetch_err_d  = fetch_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (run) begin
                    imem_addr_d = pc;
                    imem_req_d  = 1'b1;
                    state_d     = REQ;
`ifdef IF_FETCH_TIMEOUT_EN
                    wait_cnt_d  = 8'd0;
`endif
                end
            end
            REQ: begin
                // An ack always wins, even alongside ex_done or the timeout limit.
                if (imem.imem_ack) begin
                    ir_opcode_d  = imem.imem_rdata[11:8];
                    ir_operand_d = imem.imem_rdata[7:0];
                    ir_valid_d   = 1'b1;
                    imem_req_d   = 1'b0;
                    state_d      = LOAD;
                end
`ifdef IF_FETCH_TIMEOUT_EN
                else if (wait_cnt_q == WAIT_LIMIT) begin
                    imem_req_d  = 1'b0;
                    fetch_err_d = 1'b1;
                    state_d     = ERR;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
`endif
            end
            LOAD: begin
                if (ex_done) begin
                    ir_valid_d = 1'b0;
                    repc_d     = 1'b1;
                    inc_d      = 1'b1;
                    state_d    = ADVANCE;
                end
            end
            ADVANCE: begin
                // The PC unit presents its next value while REPC is high, so it is captured here.
                if (run) begin
                    imem_addr_d = pc;
                    imem_req_d  = 1'b1;
                    state_d     = REQ;
`ifdef IF_FETCH_TIMEOUT_EN
                    wait_cnt_d  = 8'd0;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
`ifdef IF_FETCH_TIMEOUT_EN
            ERR: begin
                state_d = ERR;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_ir) begin
            state_q      <= IDLE;
            imem_req_q   <= 1'b0;
            imem_addr_q  <= 10'd0;
            ir_opcode_q  <= 4'd0;
            ir_operand_q <= 8'd0;
            ir_valid_q   <= 1'b0;
            repc_q       <= 1'b0;
            inc_q        <= 1'b0;
`ifdef IF_FETCH_TIMEOUT_EN
            wait_cnt_q   <= 8'd0;
            fetch_err_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            imem_req_q   <= imem_req_d;
            imem_addr_q  <= imem_addr_d;
            ir_opcode_q  <= ir_opcode_d;
            ir_operand_q <= ir_operand_d;
            ir_valid_q   <= ir_valid_d;
            repc_q       <= repc_d;
            inc_q        <= inc_d;
`ifdef IF_FETCH_TIMEOUT_EN
            wait_cnt_q   <= wait_cnt_d;
            fetch_err_q  <= fetch_err_d;
`endif
        end
    end

    assign imem.imem_req   = imem_req_q;
    assign imem.imem_addr  = imem_addr_q;
    assign ir_opcode       = ir_opcode_q;
    assign ir_operand_addr = ir_operand_q;
    assign ir_valid        = ir_valid_q;
    assign REPC            = repc_q;
    assign INC             = inc_q;
`ifdef IF_FETCH_TIMEOUT_EN
    assign fetch_err       = fetch_err_q;
`else
    assign fetch_err       = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_ir.sv
// Directed and randomized checks of instr_fetch_ir against a transaction-level fetch/PC model.
module tb_instr_fetch_ir;
    logic       clk;
    logic       reset_ir;
    logic       run;
    logic [9:0] pc;
    logic [3:0] ir_opcode;
    logic [7:0] ir_operand_addr;
    logic       ir_valid;
    logic       ex_done;
    logic       REPC;
    logic       INC;
    logic       fetch_err;

    int total = 0;
    int bad   = 0;

    instr_fetch_ir_if imem_bus ();

    instr_fetch_ir #(.TIMEOUT_CYCLES(4)) dut (
        .clk             (clk),
        .reset_ir        (reset_ir),
        .run             (run),
        .pc              (pc),
        .imem            (imem_bus),
        .ir_opcode       (ir_opcode),
        .ir_operand_addr (ir_operand_addr),
        .ir_valid        (ir_valid),
        .ex_done         (ex_done),
        .REPC            (REPC),
        .INC             (INC),
        .fetch_err       (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ir(input string tag, input logic [11:0] word, input logic vld);
        chk({tag, "_op"}, 16'(ir_opcode), 16'(word[11:8]));
        chk({tag, "_opnd"}, 16'(ir_operand_addr), 16'(word[7:0]));
        chk({tag, "_vld"}, 16'(ir_valid), 16'(vld));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"}, 16'(imem_bus.imem_req), 16'd0);
        chk({tag, "_addr"}, 16'(imem_bus.imem_addr), 16'd0);
        chk_ir(tag, 12'h000, 1'b0);
        chk({tag, "_repc"}, 16'(REPC), 16'd0);
        chk({tag, "_inc"}, 16'(INC), 16'd0);
        chk({tag, "_err"}, 16'(fetch_err), 16'd0);
    endtask

    // Reference PC unit: opcode 8 branches to the operand address, anything else advances by one.
    function automatic logic [9:0] next_pc(input logic [9:0] cur, input logic [11:0] word);
        if (word[11:8] == 4'h8) return {2'b00, word[7:0]};
        return cur + 10'd1;
    endfunction

    initial begin
        logic [11:0] word;
        logic [11:0] held;
        logic [9:0]  exp_pc;
        logic        run_next;
        int          lat;
        int          hold;

        reset_ir = 1'b1;
        run = 1'b0;
        pc = 10'h000;
        ex_done = 1'b0;
        imem_bus.imem_ack = 1'b0;
        imem_bus.imem_rdata = 12'h000;
        step();
        step();
        chk_all_zero("reset");

        // First fetch with zero-wait memory.
        reset_ir = 1'b0;
        run = 1'b1;
        step();
        chk("req_after_release", 16'(imem_bus.imem_req), 16'd1);
        chk("addr_first", 16'(imem_bus.imem_addr), 16'h000);
        imem_bus.imem_ack = 1'b1;
        imem_bus.imem_rdata = 12'h1A5;
        step();
        imem_bus.imem_ack = 1'b0;
        chk_ir("first_load", 12'h1A5, 1'b1);
        chk("first_req_drop", 16'(imem_bus.imem_req), 16'd0);

        // Execution takes a while; IR must stay put.
        for (int i = 0; i < 5; i++) begin
            step();
            chk_ir("ir_hold", 12'h1A5, 1'b1);
            chk("no_repc_hold", 16'(REPC), 16'd0);
        end
        ex_done = 1'b1;
        step();
        ex_done = 1'b0;
        pc = 10'h001;
        chk("adv_repc", 16'(REPC), 16'd1);
        chk("adv_inc", 16'(INC), 16'd1);
        chk("adv_vld", 16'(ir_valid), 16'd0);
        chk("adv_req", 16'(imem_bus.imem_req), 16'd0);
        chk("adv_op", 16'(ir_opcode), 16'h1);
        step();
        chk("repc_one_cycle", 16'(REPC), 16'd0);
        chk("inc_one_cycle", 16'(INC), 16'd0);
        chk("req_next", 16'(imem_bus.imem_req), 16'd1);
        chk("addr_next", 16'(imem_bus.imem_addr), 16'h001);

        // Slow memory with pc moving during the wait.
        for (int i = 0; i < 3; i++) begin
            pc = 10'h3F0 + 10'(i);
            step();
            chk("wait_req", 16'(imem_bus.imem_req), 16'd1);
            chk("wait_addr", 16'(imem_bus.imem_addr), 16'h001);
            chk_ir("wait_ir", 12'h1A5, 1'b0);
        end
        imem_bus.imem_ack = 1'b1;
        imem_bus.imem_rdata = 12'h7C3;
        step();
        imem_bus.imem_ack = 1'b0;
        chk_ir("slow_load", 12'h7C3, 1'b1);

        // run dropped during LOAD: finish the instruction, then park.
        run = 1'b0;
        ex_done = 1'b1;
        step();
        ex_done = 1'b0;
        chk("park_repc", 16'(REPC), 16'd1);
        step();
        chk("park_repc_off", 16'(REPC), 16'd0);
        chk("park_req", 16'(imem_bus.imem_req), 16'd0);
        imem_bus.imem_ack = 1'b1;
        imem_bus.imem_rdata = 12'hFFF;
        step();
        imem_bus.imem_ack = 1'b0;
        chk_ir("stray_ack_idle", 12'h7C3, 1'b0);
        chk("idle_req", 16'(imem_bus.imem_req), 16'd0);

        // Reset in the middle of a request discards the response.
        run = 1'b1;
        pc = 10'h155;
        step();
        chk("pre_reset_req", 16'(imem_bus.imem_req), 16'd1);
        chk("pre_reset_addr", 16'(imem_bus.imem_addr), 16'h155);
        reset_ir = 1'b1;
        run = 1'b0;
        imem_bus.imem_ack = 1'b1;
        imem_bus.imem_rdata = 12'h555;
        step();
        chk_all_zero("mid_req_reset");
        reset_ir = 1'b0;
        step();
        imem_bus.imem_ack = 1'b0;
        chk_ir("late_ack", 12'h000, 1'b0);
        chk("late_ack_req", 16'(imem_bus.imem_req), 16'd0);

        // ex_done together with ack in REQ: ack taken, ex_done ignored.
        run = 1'b1;
        pc = 10'h020;
        step();
        imem_bus.imem_ack = 1'b1;
        imem_bus.imem_rdata = 12'h2B4;
        ex_done = 1'b1;
        step();
        imem_bus.imem_ack = 1'b0;
        ex_done = 1'b0;
        chk_ir("ack_and_done", 12'h2B4, 1'b1);
        chk("ack_and_done_repc", 16'(REPC), 16'd0);

        // Randomized instruction stream against the reference PC unit.
        reset_ir = 1'b1;
        run = 1'b0;
        step();
        reset_ir = 1'b0;
        run = 1'b1;
        exp_pc = 10'($urandom_range(0, 1023));
        pc = exp_pc;
        held = 12'h000;
        step();
        for (int n = 0; n < 40; n++) begin
            lat = $urandom_range(0, 3);
            for (int i = 0; i < lat; i++) begin
                pc = 10'($urandom);
                ex_done = 1'($urandom);
                step();
                chk("rnd_wait_req", 16'(imem_bus.imem_req), 16'd1);
                chk("rnd_wait_addr", 16'(imem_bus.imem_addr), 16'(exp_pc));
                chk_ir("rnd_wait_ir", held, 1'b0);
            end
            word = 12'($urandom);
            imem_bus.imem_ack = 1'b1;
            imem_bus.imem_rdata = word;
            ex_done = 1'($urandom);
            step();
            held = word;
            chk_ir("rnd_load", held, 1'b1);
            chk("rnd_load_req", 16'(imem_bus.imem_req), 16'd0);
            chk("rnd_load_repc", 16'(REPC), 16'd0);
            ex_done = 1'b0;
            hold = $urandom_range(0, 3);
            for (int i = 0; i < hold; i++) begin
                imem_bus.imem_ack = 1'($urandom);
                imem_bus.imem_rdata = 12'($urandom);
                step();
                chk_ir("rnd_hold", held, 1'b1);
                chk("rnd_hold_repc", 16'(REPC), 16'd0);
            end
            imem_bus.imem_ack = 1'b0;
            ex_done = 1'b1;
            step();
            ex_done = 1'b0;
            chk("rnd_repc", 16'(REPC), 16'd1);
            chk("rnd_inc", 16'(INC), 16'd1);
            chk("rnd_adv_req", 16'(imem_bus.imem_req), 16'd0);
            chk_ir("rnd_adv", held, 1'b0);
            exp_pc = next_pc(exp_pc, held);
            pc = exp_pc;
            run_next = ($urandom_range(0, 3) != 0);
            run = run_next;
            step();
            chk("rnd_repc_off", 16'(REPC), 16'd0);
            if (!run_next) begin
                chk("rnd_park_req", 16'(imem_bus.imem_req), 16'd0);
                imem_bus.imem_ack = 1'b1;
                imem_bus.imem_rdata = 12'($urandom);
                step();
                imem_bus.imem_ack = 1'b0;
                chk_ir("rnd_park_ir", held, 1'b0);
                run = 1'b1;
                step();
            end
            chk("rnd_req", 16'(imem_bus.imem_req), 16'd1);
            chk("rnd_addr", 16'(imem_bus.imem_addr), 16'(exp_pc));
        end

`ifdef IF_FETCH_TIMEOUT_EN
        // No ack at all: error after four wait cycles, sticky until reset.
        reset_ir = 1'b1;
        step();
        reset_ir = 1'b0;
        run = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("to_wait_req", 16'(imem_bus.imem_req), 16'd1);
            chk("to_wait_err", 16'(fetch_err), 16'd0);
        end
        step();
        chk("to_err", 16'(fetch_err), 16'd1);
        chk("to_err_req", 16'(imem_bus.imem_req), 16'd0);
        imem_bus.imem_ack = 1'b1;
        imem_bus.imem_rdata = 12'h9AB;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("to_err_held", 16'(fetch_err), 16'd1);
            chk("to_err_vld", 16'(ir_valid), 16'd0);
        end
        imem_bus.imem_ack = 1'b0;
        reset_ir = 1'b1;
        step();
        chk("to_err_cleared", 16'(fetch_err), 16'd0);

        // Ack on the limit cycle wins.
        reset_ir = 1'b0;
        step();
        for (int i = 0; i < 3; i++) step();
        imem_bus.imem_ack = 1'b1;
        imem_bus.imem_rdata = 12'h4D2;
        step();
        imem_bus.imem_ack = 1'b0;
        chk_ir("to_limit_ack", 12'h4D2, 1'b1);
        chk("to_limit_err", 16'(fetch_err), 16'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
